secded_ram: RTL
===============

Name: secded_ram

Overview:
- Parametrised SECDED-protected single-port word memory; next generation of the combinational Hamming encoder/decoder pair.
- Encodes on write, stores the full codeword, and checks/corrects on read.
- Writes corrected words back on single-bit errors and keeps saturating error statistics.
- Used as an ECC-protected scratch/config store behind a valid/ready command port.

Parameters:
- K, 8, data word width in bits (≥4).
- DEPTH, 16, number of words (≥2, power of two).
- CNT_W, 8, width of each error counter.
- SCRUB_IDLE, 4, idle cycles before a scrub step (used only with SECDED_SCRUB_EN).
- Derived, not overridable:
  - m = smallest m with 2^m ≥ m+K+1.
  - N = K+m+1 (codeword width).
  - AW = $clog2(DEPTH).

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_ni  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  AW  word address.
- cmd_wdata_i  in  K  write data.
- inj_mask_i  in  N  XOR mask applied to the encoded codeword on write (fault injection; tie 0 in use).
- rd_valid_o  out  1  one-cycle pulse, read result valid.
- rd_data_o  out  K  read data (corrected if SB).
- syndrome_o  out  m  Hamming syndrome of the read word.
- sb_err_o  out  1  single-bit error detected (qualified by rd_valid_o).
- sb_fix_o  out  1  corrected bit was a data bit.
- db_err_o  out  1  double-bit error detected, uncorrectable.
- busy_o  out  1  high in any state other than IDLE.
- cnt_clr_i  in  1  synchronous clear of both counters.
- sb_cnt_o  out  CNT_W  saturating single-error count.
- db_cnt_o  out  CNT_W  saturating double-error count.

Behaviour:
- Codeword layout:
  - bit 0 = overall parity p0 (even over bits 1..N-1).
  - Positions 2^i = Hamming parity bits p[i+1].
  - Remaining positions hold data bits, LSB first, ascending.
  - All-zero data encodes to the all-zero codeword.
- Reset (rst_ni=0 at a clock edge):
  - State → INIT, init pointer 0.
  - cmd_ready_o=0, busy_o=1, rd_valid_o=0.
  - rd_data_o, syndrome_o, sb_err_o, sb_fix_o, db_err_o = 0.
  - Counters = 0.
  - Reset mid-operation aborts any access; no write-back is completed.
- FSM states: INIT, IDLE, RD, CHK, FIX (plus SCR_RD, SCR_CHK with macro).
- INIT: writes the zero codeword to address ptr each cycle; ptr increments; after DEPTH cycles (ptr=DEPTH-1 written) → IDLE.
- IDLE:
  - cmd_ready_o=1.
  - Write accepted: codeword = enc(wdata) ^ inj_mask_i, stored that edge, stay IDLE; back-to-back writes allowed.
  - Read accepted: → RD.
- RD: registered memory read of the latched address → CHK.
- CHK:
  - Decodes the codeword and drives outputs, registered; rd_valid_o pulses in the cycle after CHK. Read latency = 3 cycles from accept edge to rd_valid_o.
  - syndrome=0, parity ok: clean.
  - syndrome≠0, parity fail: SB; flip bit at position syndrome; sb_fix_o=1 if that position is a data bit.
  - syndrome=0, parity fail: SB in p0; sb_fix_o=0.
  - syndrome≠0, parity ok: DB; rd_data_o = raw uncorrected data bits; no write-back.
  - SB → FIX; otherwise → IDLE.
- FIX: writes the corrected full codeword to the same address → IDLE. Memory is single-port: exactly one access per cycle.
- Flags hold until the next rd_valid_o; rd_valid_o is never asserted for INIT/FIX/scrub.
- Counters:
  - +1 per SB or DB decode, including scrub decodes.
  - Saturate at 2^CNT_W-1.
  - cnt_clr_i wins over a same-cycle increment.
- Read/write address out of range: impossible (DEPTH power of two).

Optional Feature:
- SECDED_SCRUB_EN defined:
  - Background scrubber with its own pointer, reset 0.
  - After SCRUB_IDLE consecutive IDLE cycles with no accepted command: IDLE → SCR_RD → SCR_CHK → (FIX on SB) → IDLE; pointer increments, wraps DEPTH-1 → 0.
  - cmd_ready_o=0 during a scrub step (max 3 cycles); idle counter restarts on any accepted command or completed step.
  - Scrub updates counters; no rd_valid_o.
- Undefined: no scrub states, pointer or idle counter; memory is checked only on reads.

Test Plan (K=8, DEPTH=16, m=4, N=13):
- Release reset → busy_o=1 for exactly 16 cycles, then cmd_ready_o=1; read addr 5 → rd_data_o=0x00, all flags 0, 3-cycle latency.
- Write 0xA5 to addr 3, mask 0; read addr 3 → 0xA5, syndrome 0, sb/db 0, counters 0.
- Write 0xA5 to addr 3 with inj_mask bit 3 set → read gives 0xA5, syndrome=3, sb_err=1, sb_fix=1, sb_cnt=1, busy for FIX; re-read → clean, sb_cnt still 1.
- Mask bit 0 only → 0xA5, syndrome 0, sb_err=1, sb_fix=0. Mask bits 3 and 5 → db_err=1, sb_err=0, rd_data_o=raw bits, db_cnt+1; re-read identical.
- CNT_W=2: four SB reads → sb_cnt_o=3 (saturated); cnt_clr_i asserted in a decode cycle → 0 next cycle.
- Macro on: inject SB at addr 7, idle 80 cycles, read addr 7 → clean, sb_cnt_o=1. Command issued mid-scrub waits ≤3 cycles for cmd_ready_o.

Source files
------------

// File: rtl/secded_ram.sv
// secded_ram: SECDED (extended Hamming) protected single-port word memory.
// Latency: writes stored on the accept edge; reads return rd_valid_o 3 cycles after the accept cycle.
// Backpressure: cmd_ready_o is high only in IDLE; INIT, reads, write-back (and scrub steps) hold it low.
//
// Optional feature macro: SECDED_SCRUB_EN enables a background scrubber that
// walks the array during idle periods and repairs single-bit errors.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake; cmd_we_i selects write (1) or read (0)
//   cmd_addr_i, cmd_wdata_i  word address and write data
//   inj_mask_i               XOR mask applied to the stored codeword on write (fault injection)
//   rd_valid_o, rd_data_o    one-cycle read result pulse and (corrected) data
//   syndrome_o, sb_err_o,    decode status of the last read; held until the next rd_valid_o
//   sb_fix_o, db_err_o
//   busy_o                   high whenever the controller is not in IDLE
//   cnt_clr_i, sb_cnt_o,     saturating single/double error counters with synchronous clear
//   db_cnt_o
module secded_ram #(
  parameter int K          = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 8,
  parameter int SCRUB_IDLE = 4,
  // Smallest M with 2^M >= M+K+1, reached by fixed-point iteration from below.
  localparam int M  = $clog2(K + 1 + $clog2(K + 1 + $clog2(K + 1 + $clog2(K + 1)))),
  localparam int N  = K + M + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [AW-1:0]    cmd_addr_i,
  input  logic [K-1:0]     cmd_wdata_i,
  input  logic [N-1:0]     inj_mask_i,
  output logic             rd_valid_o,
  output logic [K-1:0]     rd_data_o,
  output logic [M-1:0]     syndrome_o,
  output logic             sb_err_o,
  output logic             sb_fix_o,
  output logic             db_err_o,
  output logic             busy_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o
);

  if (K < 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1 || SCRUB_IDLE < 1)
  begin : g_param_check
    $error("secded_ram: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_CHK,
    S_FIX
`ifdef SECDED_SCRUB_EN
    ,
    S_SCR_RD,
    S_SCR_CHK
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Code helpers. Position 0 is overall parity, powers of two are Hamming
  // parity bits, every other position carries data, LSB first.
  // ---------------------------------------------------------------------------
  function automatic logic is_data_pos(input int p);
    return (p != 0) && ((p & (p - 1)) != 0);
  endfunction

  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    logic [N-1:0] cw;
    logic         par;
    int           di;
    cw = '0;
    di = 0;
    for (int p = 1; p < N; p++) begin
      if (is_data_pos(p)) begin
        cw[p] = d[di];
        di++;
      end
    end
    // Parity slot is still zero while it is folded into its own sum.
    for (int i = 0; i < M; i++) begin
      par = 1'b0;
      for (int p = 1; p < N; p++) begin
        if (((p >> i) & 1) == 1) par ^= cw[p];
      end
      cw[1 << i] = par;
    end
    cw[0] = ^cw[N-1:1];
    return cw;
  endfunction

  function automatic logic [M-1:0] syndrome_of(input logic [N-1:0] cw);
    logic [M-1:0] s;
    s = '0;
    for (int p = 1; p < N; p++) begin
      if (cw[p]) s ^= M'(p);
    end
    return s;
  endfunction

  function automatic logic [K-1:0] data_of(input logic [N-1:0] cw);
    logic [K-1:0] d;
    int           di;
    d  = '0;
    di = 0;
    for (int p = 1; p < N; p++) begin
      if (is_data_pos(p)) begin
        d[di] = cw[p];
        di++;
      end
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [AW-1:0]    init_ptr;
  logic [AW-1:0]    addr_q;
  logic [N-1:0]     fix_cw_q;
  logic [N-1:0]     rd_cw;
  logic [N-1:0]     mem [DEPTH];

  logic             rd_valid_q;
  logic [K-1:0]     rd_data_q;
  logic [M-1:0]     syndrome_q;
  logic             sb_err_q;
  logic             sb_fix_q;
  logic             db_err_q;
  logic [CNT_W-1:0] sb_cnt_q;
  logic [CNT_W-1:0] db_cnt_q;

`ifdef SECDED_SCRUB_EN
  localparam int IW = $clog2(SCRUB_IDLE + 1);
  logic [AW-1:0]    scrub_ptr;
  logic [IW-1:0]    idle_cnt;
`endif

  logic             accept;
  logic             chk_active;

  assign accept = cmd_valid_i && (state == S_IDLE);

  always_comb begin
    chk_active = (state == S_CHK);
`ifdef SECDED_SCRUB_EN
    if (state == S_SCR_CHK) chk_active = 1'b1;
`endif
  end

  // ---------------------------------------------------------------------------
  // Decode of the codeword fetched in RD / SCR_RD.
  // ---------------------------------------------------------------------------
  logic [M-1:0] dec_syn;
  logic         dec_pfail;
  logic         dec_sb;
  logic         dec_db;
  logic         dec_fix_data;
  logic [N-1:0] dec_cw;
  logic [K-1:0] dec_data;

  always_comb begin
    dec_syn   = syndrome_of(rd_cw);
    dec_pfail = ^rd_cw;
    // A parity failure whose syndrome points past the codeword cannot be a
    // single flip (three or more errors); it is reported as uncorrectable.
    dec_sb    = dec_pfail && (int'(dec_syn) < N);
    dec_db    = (!dec_pfail && (dec_syn != '0)) || (dec_pfail && (int'(dec_syn) >= N));
    dec_fix_data = dec_sb && is_data_pos(int'(dec_syn));
    dec_cw    = rd_cw;
    for (int p = 0; p < N; p++) begin
      if (dec_sb && (int'(dec_syn) == p)) dec_cw[p] = ~rd_cw[p];
    end
    // On DB dec_cw is the raw word, so this yields the uncorrected data bits.
    dec_data  = data_of(dec_cw);
  end

  // ---------------------------------------------------------------------------
  // Single memory port: at most one write or one read per cycle.
  // ---------------------------------------------------------------------------
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [N-1:0]  mem_wd;
  logic          mem_re;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr_q;
    mem_wd = fix_cw_q;
    mem_re = 1'b0;
    case (state)
      S_INIT: begin
        mem_we = 1'b1;
        mem_wa = init_ptr;
        mem_wd = '0;
      end
      S_IDLE: begin
        mem_we = accept && cmd_we_i;
        mem_wa = cmd_addr_i;
        mem_wd = encode(cmd_wdata_i) ^ inj_mask_i;
      end
      S_RD:     mem_re = 1'b1;
      S_FIX:    mem_we = 1'b1;
`ifdef SECDED_SCRUB_EN
      S_SCR_RD: mem_re = 1'b1;
`endif
      default: ;
    endcase
    // A reset edge aborts any pending write, including a FIX write-back.
    if (!rst_ni) mem_we = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (mem_re) rd_cw <= mem[addr_q];
  end

  // ---------------------------------------------------------------------------
  // Controller, status outputs and counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= S_INIT;
      init_ptr   <= '0;
      addr_q     <= '0;
      fix_cw_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      syndrome_q <= '0;
      sb_err_q   <= 1'b0;
      sb_fix_q   <= 1'b0;
      db_err_q   <= 1'b0;
      sb_cnt_q   <= '0;
      db_cnt_q   <= '0;
`ifdef SECDED_SCRUB_EN
      scrub_ptr  <= '0;
      idle_cnt   <= '0;
`endif
    end else begin
      rd_valid_q <= 1'b0;

      if (cnt_clr_i) begin
        sb_cnt_q <= '0;
        db_cnt_q <= '0;
      end else if (chk_active) begin
        if (dec_sb && (sb_cnt_q != {CNT_W{1'b1}})) sb_cnt_q <= sb_cnt_q + CNT_W'(1);
        if (dec_db && (db_cnt_q != {CNT_W{1'b1}})) db_cnt_q <= db_cnt_q + CNT_W'(1);
      end

      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + AW'(1);
          if (init_ptr == AW'(DEPTH - 1)) state <= S_IDLE;
        end
        S_IDLE: begin
`ifdef SECDED_SCRUB_EN
          if (accept) begin
            idle_cnt <= '0;
            if (!cmd_we_i) begin
              addr_q <= cmd_addr_i;
              state  <= S_RD;
            end
          end else if (idle_cnt == IW'(SCRUB_IDLE - 1)) begin
            idle_cnt <= '0;
            addr_q   <= scrub_ptr;
            state    <= S_SCR_RD;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
`else
          if (accept && !cmd_we_i) begin
            addr_q <= cmd_addr_i;
            state  <= S_RD;
          end
`endif
        end
        S_RD: state <= S_CHK;
        S_CHK: begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= dec_data;
          syndrome_q <= dec_syn;
          sb_err_q   <= dec_sb;
          sb_fix_q   <= dec_fix_data;
          db_err_q   <= dec_db;
          fix_cw_q   <= dec_cw;
          state      <= dec_sb ? S_FIX : S_IDLE;
        end
        S_FIX: state <= S_IDLE;
`ifdef SECDED_SCRUB_EN
        S_SCR_RD: state <= S_SCR_CHK;
        S_SCR_CHK: begin
          fix_cw_q  <= dec_cw;
          scrub_ptr <= scrub_ptr + AW'(1);
          state     <= dec_sb ? S_FIX : S_IDLE;
        end
`endif
        default: state <= S_INIT;
      endcase
    end
  end

  assign cmd_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign syndrome_o  = syndrome_q;
  assign sb_err_o    = sb_err_q;
  assign sb_fix_o    = sb_fix_q;
  assign db_err_o    = db_err_q;
  assign sb_cnt_o    = sb_cnt_q;
  assign db_cnt_o    = db_cnt_q;

endmodule
